clk_mux_n_sw: RTL
=================

Name: clk_mux_n_sw

Overview:
- N-input glitch-free clock switch.
- A control FSM in the clk1 domain accepts switch requests through a req/busy/done handshake.
- It sequences channel gates "break-before-make" across the N asynchronous source clocks and reports the active source.
- Sits at the clock-generation level, ahead of the functional clock tree. It replaces fixed 2-input muxes wherever more than two sources or related/unrelated mixed sources occur.

Parameters:
- N, 4, number of source clocks (2..16).
- SYNC_STAGES, 2, synchroniser depth per channel, in the source domain (2..4).
- ACK_STAGES, 2, synchroniser depth for gate status back into clk1.
- RESET_SEL, 0, source enabled automatically after reset (0..N-1).
- TIMEOUT_CYCLES, 1024, clk1 cycles allowed per DRAIN/ENABLE phase (feature only).

Ports:
- clk1, in, 1, control clock; all handshake signals are synchronous to it.
- rst_n, in, 1, asynchronous, active-low reset.
- clk_src, in, N, source clocks; bit i is channel i.
- sw_req, in, 1, one-cycle switch request; sampled only when sw_busy=0.
- sw_sel, in, SELW=$clog2(N+1), target index; value >= N means "all gates off".
- sw_busy, out, 1, switch sequence in progress.
- sw_done, out, 1, one-cycle pulse when a sequence completes.
- cur_sel, out, SELW, index of the active source; valid only when cur_valid=1.
- cur_valid, out, 1, exactly one gate is confirmed on.
- clk_out, out, 1, OR of (gate_i AND clk_src[i]).
- timeout_err, out, 1, sticky error flag (feature only; otherwise tied 0).

Behaviour:
- Reset values:
  - All channel gate flops 0, so clk_out=0.
  - en_req=0, cur_valid=0, cur_sel=0, sw_done=0, timeout_err=0.
  - sw_busy=1, FSM=ENABLE, target=RESET_SEL.
- Channel i:
  - en_req[i] from clk1 is ANDed with NOT(any other gate_j) and passed through SYNC_STAGES flops on posedge clk_src[i].
  - The final gate_i flop is clocked on negedge clk_src[i], so the output enable only changes while the source is low. This guarantees no runt pulse.
  - gate_i is synchronised back to clk1 through ACK_STAGES flops, giving ack[i].
- FSM states:
  - IDLE:
    - sw_busy=0.
    - sw_req with sw_sel==cur_sel and cur_valid=1: go to DONE; gates are untouched.
    - Any other sw_req: latch target=sw_sel, go to DRAIN.
  - DRAIN:
    - en_req=0.
    - Wait until ack==0, then go to ENABLE. If target>=N, go to DONE instead.
  - ENABLE:
    - en_req=onehot(target).
    - Wait until ack==onehot(target), then go to DONE.
  - DONE:
    - sw_done=1 for one cycle.
    - Update cur_sel=target and cur_valid=(target<N).
    - Go to IDLE.
- sw_busy is 1 in DRAIN, ENABLE and DONE, and 0 in IDLE.
- sw_req while busy is ignored; there is no queueing.
- During DRAIN and ENABLE, cur_valid=0.
- Switch latency, nominal: (SYNC_STAGES+1) old-clock cycles + ACK_STAGES+1 clk1 cycles, then the same again with the new clock, plus 1 DONE cycle.
- Gap guarantee: clk_out is held low for at least one full low phase between the old source's last edge and the new source's first edge.
- Reset mid-sequence: all gates drop asynchronously, immediately. After release, the block re-runs the boot ENABLE of RESET_SEL and ends with a sw_done pulse.
- A stopped source clock hangs the affected phase (without the optional feature).

Optional Feature:
- Macro: CLK_MUX_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to DRAIN/ENABLE and increments every clk1 cycle in those states.
  - At TIMEOUT_CYCLES: set timeout_err (sticky until reset), force en_req=0, and go to DONE with cur_valid=0.
  - sw_done still pulses, and the FSM returns to IDLE so a new request can be issued.
- Without the macro: no counter, timeout_err tied to 0, and a dead clock stalls the FSM indefinitely.

Decomposition:
- Package clk_mux_pkg:
  - FSM state enum {IDLE, DRAIN, ENABLE, DONE}.
  - SELW derivation function.
  - Onehot-decode function.
- Sub-module clk_mux_chan, instantiated N times:
  - Inputs: en_req bit, other-gates-off term, clk_src[i], rst_n.
  - Contents: SYNC_STAGES posedge flops plus the negedge gate flop.
  - Output: gate_i.
- The clk1 FSM, ack synchronisers and output OR live in the top level.

Test Plan:
- Reset release, N=4, RESET_SEL=2, clk_src periods 10/13/7/29 ns -> sw_done pulses once; cur_sel=2, cur_valid=1; clk_out follows clk_src[2]; before that clk_out=0.
- sw_req sel=0 from active sel 2 -> busy rises next cycle; clk_out low for at least one gap phase; no pulse narrower than min(half-period of clk_src[2], half-period of clk_src[0]); sw_done pulses; cur_sel=0.
- sw_req sel=0 while already on 0 -> sw_done 2 cycles later; no gate activity; clk_out uninterrupted.
- sw_req sel=4 (off) -> clk_out stays 0 after drain; cur_valid=0; a following sw_req sel=3 re-enables clk_src[3].
- rst_n asserted in the middle of ENABLE -> clk_out=0 immediately; after release the RESET_SEL boot sequence completes normally.
- CLK_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=64, clk_src[1] held static, sw_req sel=1 -> timeout_err=1 at cycle 64 of ENABLE; sw_done pulses; cur_valid=0; a later sw_req sel=0 succeeds.

Source files
------------

// File: rtl/clk_mux_pkg.sv
// clk_mux_pkg: shared FSM encoding and helper functions for the N-input
// glitch-free clock switch (clk_mux_n_sw / clk_mux_chan).
package clk_mux_pkg;

  // Control FSM states, clk1 domain.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_DONE   = 2'd3
  } mux_state_e;

  // Largest supported channel count; sizes the one-hot helper.
  localparam int MAX_SRC = 16;

  // Select width: one code per source plus the "all gates off" code.
  function automatic int sel_width(input int n);
    return $clog2(n + 32'sd1);
  endfunction

  // One-hot decode; indices past the last channel decode to all zeros,
  // which is exactly the "all gates off" request.
  function automatic logic [MAX_SRC-1:0] onehot16(input logic [4:0] idx);
    logic [MAX_SRC-1:0] v;
    v = {MAX_SRC{1'b0}};
    if (idx < 5'd16) begin
      v[idx[3:0]] = 1'b1;
    end else begin
      v = {MAX_SRC{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/clk_mux_chan.sv
// clk_mux_chan: one source channel of the clock switch. The clk1 enable,
// qualified by "every other gate is off", is resynchronised on the source's
// rising edge and applied to the gate on the falling edge, so the gate only
// ever changes while the source clock is low.
module clk_mux_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_src,
  input  logic rst_n,
  input  logic i_en_req,
  input  logic i_others_off,
  output logic o_gate
);

  logic                   w_en_d;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_gate;

  assign w_en_d = i_en_req & i_others_off;

  // Resynchronise the qualified enable into the source clock domain.
  always_ff @(posedge i_clk_src or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_en_d};
    end
  end

  // Move the gate only during the low phase so no runt pulse can escape.
  always_ff @(negedge i_clk_src or negedge rst_n) begin
    if (!rst_n) begin
      r_gate <= 1'b0;
    end else begin
      r_gate <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_gate = r_gate;

endmodule

// File: rtl/clk_mux_n_sw.sv
// clk_mux_n_sw: N-input glitch-free clock switch. A clk1 FSM takes switch
// requests (req/busy/done), drains all gates, then enables the target gate
// (break-before-make) and reports the confirmed active source.
// Optional build macro: CLK_MUX_TIMEOUT_EN adds a per-phase watchdog that
// aborts a DRAIN/ENABLE phase after TIMEOUT_CYCLES clk1 cycles and raises a
// sticky timeout_err; without it timeout_err is tied low.
module clk_mux_n_sw
  import clk_mux_pkg::*;
#(
  parameter  int N              = 4,
  parameter  int SYNC_STAGES    = 2,
  parameter  int ACK_STAGES     = 2,
  parameter  int RESET_SEL      = 0,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int SELW           = sel_width(N)
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic [N-1:0]    clk_src,
  input  logic            sw_req,
  input  logic [SELW-1:0] sw_sel,
  output logic            sw_busy,
  output logic            sw_done,
  output logic [SELW-1:0] cur_sel,
  output logic            cur_valid,
  output logic            clk_out,
  output logic            timeout_err
);

  localparam logic [SELW-1:0] NSEL = SELW'(N);
  localparam logic [SELW-1:0] RSEL = SELW'(RESET_SEL);

  if ((N < 2) || (N > MAX_SRC) || (SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
      (ACK_STAGES < 2) || (RESET_SEL < 0) || (RESET_SEL >= N) ||
      (TIMEOUT_CYCLES < 2)) begin : g_param_err
    $error("clk_mux_n_sw: parameter out of supported range");
  end

  mux_state_e                   r_state;
  logic [SELW-1:0]              r_target;
  logic [N-1:0]                 r_en_req;
  logic                         r_busy;
  logic                         r_done;
  logic [SELW-1:0]              r_cur_sel;
  logic                         r_cur_valid;
  logic [ACK_STAGES-1:0][N-1:0] r_ack_sync;

  logic [N-1:0] w_gate;
  logic [N-1:0] w_others_off;
  logic [N-1:0] w_ack;
  logic [N-1:0] w_tgt_oh;
  logic         w_tgt_on;
  logic         w_tmo_fire;
  logic         w_tmo_hit;

  // Channels: each may only turn on while every other gate is off.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign w_others_off[gi] = ~|(w_gate & ~N'(onehot16(5'(gi))));

    clk_mux_chan #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .i_clk_src    (clk_src[gi]),
      .rst_n        (rst_n),
      .i_en_req     (r_en_req[gi]),
      .i_others_off (w_others_off[gi]),
      .o_gate       (w_gate[gi])
    );
  end

  assign w_tgt_oh = N'(onehot16(5'(r_target)));
  assign w_tgt_on = (r_target < NSEL);
  assign w_ack    = r_ack_sync[ACK_STAGES-1];

  // Bring the gate states back into clk1 for the handshake.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= {(ACK_STAGES*N){1'b0}};
    end else begin
      r_ack_sync <= {r_ack_sync[ACK_STAGES-2:0], w_gate};
    end
  end

`ifdef CLK_MUX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] r_tcnt;
  logic           r_tmo_hit;
  logic           r_timeout_err;

  assign w_tmo_fire = ((r_state == ST_DRAIN) || (r_state == ST_ENABLE)) &&
                      (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_hit  = r_tmo_hit;

  // Phase watchdog: restarts on every DRAIN/ENABLE entry, flags a dead source.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt        <= {TCW{1'b0}};
      r_tmo_hit     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state != ST_DRAIN) && (r_state != ST_ENABLE)) begin
        r_tcnt <= {TCW{1'b0}};
      end else if (w_tmo_fire) begin
        r_tcnt <= {TCW{1'b0}};
      end else if ((r_state == ST_DRAIN) && (w_ack == {N{1'b0}})) begin
        r_tcnt <= {TCW{1'b0}};
      end else begin
        r_tcnt <= r_tcnt + TCW'(1);
      end
      if (w_tmo_fire) begin
        r_tmo_hit     <= 1'b1;
        r_timeout_err <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_tmo_hit <= 1'b0;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_tmo_fire  = 1'b0;
  assign w_tmo_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Switch sequencer: drain all gates, enable the target, report completion.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ENABLE;
      r_target    <= RSEL;
      r_en_req    <= {N{1'b0}};
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_cur_sel   <= {SELW{1'b0}};
      r_cur_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (sw_req) begin
            r_busy   <= 1'b1;
            r_target <= sw_sel;
            if ((sw_sel == r_cur_sel) && r_cur_valid) begin
              r_state <= ST_DONE;
            end else begin
              r_state     <= ST_DRAIN;
              r_en_req    <= {N{1'b0}};
              r_cur_valid <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          r_en_req <= {N{1'b0}};
          if (w_tmo_fire) begin
            r_state <= ST_DONE;
          end else if (w_ack == {N{1'b0}}) begin
            if (w_tgt_on) begin
              r_state  <= ST_ENABLE;
              r_en_req <= w_tgt_oh;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_ENABLE: begin
          if (w_tmo_fire) begin
            r_en_req <= {N{1'b0}};
            r_state  <= ST_DONE;
          end else begin
            r_en_req <= w_tgt_oh;
            if (w_ack == w_tgt_oh) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_cur_sel   <= r_target;
          r_cur_valid <= w_tgt_on & ~w_tmo_hit;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_en_req <= {N{1'b0}};
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign sw_busy   = r_busy;
  assign sw_done   = r_done;
  assign cur_sel   = r_cur_sel;
  assign cur_valid = r_cur_valid;
  assign clk_out   = |(w_gate & clk_src);

endmodule
